id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage LEGv8 core. Sits directly downstream of the register file.
- Captures rd1/rd2 (already write-forwarded by the register file), immediate, PC, register addresses and control from decode; presents them registered to EX.
- Contains load-use hazard detection: inserts a bubble into EX and tells IF/ID to hold for one cycle.
- Honours an external stall (memory wait) and a flush (taken branch).

Parameters:
- DW, 64, data/PC/immediate width
- AW, 5, register address width
- CTRL_W, 8, width of the opaque EX/MEM/WB control bundle (ALU op, ALUSrc, MemWrite, Branch, MemtoReg, ...)
- ZR, 31, index of XZR; never a hazard source

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- stall  in  1  external stall; hold all EX fields
- flush  in  1  replace incoming instruction with a bubble
- id_rd1  in  DW  register file read data 1
- id_rd2  in  DW  register file read data 2
- id_imm  in  DW  sign-extended immediate
- id_pc  in  DW  PC of decoded instruction
- id_ra1  in  AW  source register 1
- id_ra2  in  AW  source register 2
- id_wa  in  AW  destination register
- id_use_ra1  in  1  instruction reads ra1
- id_use_ra2  in  1  instruction reads ra2
- id_valid  in  1  decode slot holds a real instruction
- id_regwrite  in  1  writes register file
- id_memread  in  1  load instruction
- id_ctrl  in  CTRL_W  remaining control bits
- ex_rd1, ex_rd2, ex_imm, ex_pc  out  DW  registered copies
- ex_ra1, ex_ra2, ex_wa  out  AW  registered copies
- ex_valid, ex_regwrite, ex_memread  out  1  registered copies
- ex_ctrl  out  CTRL_W  registered copy
- hazard_stall  out  1  combinational; upstream holds PC and IF/ID when high
- bubble_cnt  out  32  present only with IDEX_BUBBLE_CNT_EN

Behaviour:
- Reset (asynchronous, any time, including mid-stall): ex_valid, ex_regwrite, ex_memread and ex_ctrl = 0; all data fields = 0; ex_ra1, ex_ra2 and ex_wa = ZR.
- Reset therefore never produces a false hazard.

hazard_stall (combinational) is high only when all of the following hold:
- ex_valid & ex_memread & id_valid
- ex_wa != ZR
- (id_use_ra1 & id_ra1 == ex_wa) | (id_use_ra2 & id_ra2 == ex_wa)

Per-edge priority, highest first:
1. flush: load bubble.
2. stall: hold every ex_* field unchanged.
3. hazard_stall: load bubble.
4. Otherwise: load all id_* fields. Latency is 1 cycle.

Bubble and related rules:
- Bubble: ex_valid, ex_regwrite, ex_memread and ex_ctrl = 0; data fields = 0; addresses = ZR.
- stall with a pending hazard: EX keeps the load; hazard_stall stays high. The upstream stall is the OR of both signals, so nothing is lost.
- One hazard yields exactly one bubble. On the next cycle EX holds the bubble (ex_memread = 0), so hazard_stall drops and the held instruction loads.
- flush together with hazard_stall: bubble. hazard_stall still asserts combinationally; the upstream flush handles the refetch.
- id_valid = 0 passes through as a bubble (ex_regwrite is not forced, but ex_valid = 0). EX/MEM must gate writes with ex_valid.
- No arithmetic on data: fields are copied bit-exact at width.

Optional Feature:
- IDEX_BUBBLE_CNT_EN defined: 32-bit bubble_cnt port.
  - Increments by 1 on each edge where a hazard bubble is loaded (hazard_stall & !stall & !flush).
  - Flush bubbles are not counted.
  - Saturates at 0xFFFF_FFFF. Reset to 0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Assert reset mid-cycle, with id_* nonzero → outputs immediately ex_valid=0, ex_wa=31, ex_rd1=0; hazard_stall=0.
- LDUR X9 into EX (memread=1, wa=9), then ADD reading ra1=9 (use_ra1=1) → hazard_stall=1 for one cycle. EX gets a bubble (ex_valid=0). Next edge loads the ADD with ex_ra1=9; bubble_cnt=1 when enabled.
- LDUR X31 in EX, next instruction reads ra2=31 → hazard_stall=0; no bubble.
- stall=1 for 3 cycles with ex_rd1=0x55 while id_rd1 changes → ex_rd1 stays 0x55; bubble_cnt unchanged.
- Hazard present and stall=1 → EX holds the load and hazard_stall stays 1. stall drops → exactly one bubble, then the dependent instruction.
- flush=1 with id_valid=1 and id_rd2=0xABCD → next cycle ex_valid=0, ex_rd2=0, ex_ctrl=0; bubble_cnt unchanged.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, external stall and flush.
// Define IDEX_BUBBLE_CNT_EN to add a saturating 32-bit count of hazard bubbles (bubble_cnt).
module id_ex_stage #(
  parameter int unsigned DW     = 64,
  parameter int unsigned AW     = 5,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned ZR     = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [DW-1:0]     id_rd1,
  input  logic [DW-1:0]     id_rd2,
  input  logic [DW-1:0]     id_imm,
  input  logic [DW-1:0]     id_pc,
  input  logic [AW-1:0]     id_ra1,
  input  logic [AW-1:0]     id_ra2,
  input  logic [AW-1:0]     id_wa,
  input  logic              id_use_ra1,
  input  logic              id_use_ra2,
  input  logic              id_valid,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic [DW-1:0]     ex_rd1,
  output logic [DW-1:0]     ex_rd2,
  output logic [DW-1:0]     ex_imm,
  output logic [DW-1:0]     ex_pc,
  output logic [AW-1:0]     ex_ra1,
  output logic [AW-1:0]     ex_ra2,
  output logic [AW-1:0]     ex_wa,
  output logic              ex_valid,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic [CTRL_W-1:0] ex_ctrl,
`ifdef IDEX_BUBBLE_CNT_EN
  output logic [31:0]       bubble_cnt,
`endif
  output logic              hazard_stall
);

  localparam logic [AW-1:0] ZrAddr = AW'(ZR);

  logic [DW-1:0]     r_rd1, r_rd2, r_imm, r_pc;
  logic [AW-1:0]     r_ra1, r_ra2, r_wa;
  logic              r_valid, r_regwrite, r_memread;
  logic [CTRL_W-1:0] r_ctrl;

  logic w_hazard;
  logic w_bubble;
  logic w_load;

  // XZR is never a real producer, so a load targeting it cannot cause a hazard.
  always_comb begin
    w_hazard = r_valid & r_memread & id_valid & (r_wa != ZrAddr) &
               ((id_use_ra1 & (id_ra1 == r_wa)) | (id_use_ra2 & (id_ra2 == r_wa)));
    w_bubble = flush | (~stall & w_hazard);
    w_load   = ~flush & ~stall & ~w_hazard;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_imm      <= '0;
      r_pc       <= '0;
      r_ra1      <= ZrAddr;
      r_ra2      <= ZrAddr;
      r_wa       <= ZrAddr;
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_ctrl     <= '0;
    end else if (w_bubble) begin
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_imm      <= '0;
      r_pc       <= '0;
      r_ra1      <= ZrAddr;
      r_ra2      <= ZrAddr;
      r_wa       <= ZrAddr;
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_ctrl     <= '0;
    end else if (w_load) begin
      r_rd1      <= id_rd1;
      r_rd2      <= id_rd2;
      r_imm      <= id_imm;
      r_pc       <= id_pc;
      r_ra1      <= id_ra1;
      r_ra2      <= id_ra2;
      r_wa       <= id_wa;
      r_valid    <= id_valid;
      r_regwrite <= id_regwrite;
      r_memread  <= id_memread;
      r_ctrl     <= id_ctrl;
    end
  end

  assign ex_rd1       = r_rd1;
  assign ex_rd2       = r_rd2;
  assign ex_imm       = r_imm;
  assign ex_pc        = r_pc;
  assign ex_ra1       = r_ra1;
  assign ex_ra2       = r_ra2;
  assign ex_wa        = r_wa;
  assign ex_valid     = r_valid;
  assign ex_regwrite  = r_regwrite;
  assign ex_memread   = r_memread;
  assign ex_ctrl      = r_ctrl;
  assign hazard_stall = w_hazard;

`ifdef IDEX_BUBBLE_CNT_EN
  logic [31:0] r_bubble_cnt;

  // Only hazard bubbles count; flush bubbles are excluded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bubble_cnt <= '0;
    end else if (w_hazard & ~stall & ~flush & (r_bubble_cnt != 32'hFFFF_FFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic vs. a reference model.
module tb_id_ex_stage;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset, stall, flush;
  logic [DW-1:0] id_rd1, id_rd2, id_imm, id_pc;
  logic [AW-1:0] id_ra1, id_ra2, id_wa;
  logic          id_use_ra1, id_use_ra2, id_valid, id_regwrite, id_memread;
  logic [CW-1:0] id_ctrl;
  logic [DW-1:0] ex_rd1, ex_rd2, ex_imm, ex_pc;
  logic [AW-1:0] ex_ra1, ex_ra2, ex_wa;
  logic          ex_valid, ex_regwrite, ex_memread;
  logic [CW-1:0] ex_ctrl;
  logic          hazard_stall;
  logic [31:0]   bubble_cnt;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .id_rd1      (id_rd1),
    .id_rd2      (id_rd2),
    .id_imm      (id_imm),
    .id_pc       (id_pc),
    .id_ra1      (id_ra1),
    .id_ra2      (id_ra2),
    .id_wa       (id_wa),
    .id_use_ra1  (id_use_ra1),
    .id_use_ra2  (id_use_ra2),
    .id_valid    (id_valid),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .id_ctrl     (id_ctrl),
    .ex_rd1      (ex_rd1),
    .ex_rd2      (ex_rd2),
    .ex_imm      (ex_imm),
    .ex_pc       (ex_pc),
    .ex_ra1      (ex_ra1),
    .ex_ra2      (ex_ra2),
    .ex_wa       (ex_wa),
    .ex_valid    (ex_valid),
    .ex_regwrite (ex_regwrite),
    .ex_memread  (ex_memread),
    .ex_ctrl     (ex_ctrl),
`ifdef IDEX_BUBBLE_CNT_EN
    .bubble_cnt  (bubble_cnt),
`endif
    .hazard_stall(hazard_stall)
  );

`ifndef IDEX_BUBBLE_CNT_EN
  assign bubble_cnt = '0;
`endif

  // Reference model: the instruction currently occupying EX.
  typedef struct {
    logic          valid, regwrite, memread;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] rd1, rd2, imm, pc;
    logic [AW-1:0] ra1, ra2, wa;
  } slot_t;

  slot_t       m;
  int unsigned m_bubbles;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        last_hz;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic slot_t empty_slot();
    slot_t s;
    s.valid = 0; s.regwrite = 0; s.memread = 0; s.ctrl = '0;
    s.rd1 = '0; s.rd2 = '0; s.imm = '0; s.pc = '0;
    s.ra1 = 5'd31; s.ra2 = 5'd31; s.wa = 5'd31;
    return s;
  endfunction

  function automatic slot_t decoded_slot();
    slot_t s;
    s.valid = id_valid; s.regwrite = id_regwrite; s.memread = id_memread; s.ctrl = id_ctrl;
    s.rd1 = id_rd1; s.rd2 = id_rd2; s.imm = id_imm; s.pc = id_pc;
    s.ra1 = id_ra1; s.ra2 = id_ra2; s.wa = id_wa;
    return s;
  endfunction

  // A load in EX whose (non-XZR) destination is read by a real instruction in decode.
  function automatic logic model_hazard();
    logic dep;
    dep = (id_use_ra1 && id_ra1 == m.wa) || (id_use_ra2 && id_ra2 == m.wa);
    return m.valid && m.memread && id_valid && (m.wa != 5'd31) && dep;
  endfunction

  task automatic check_outputs(input string tag);
    check_eq({tag, ".valid"}, ex_valid, m.valid);
    check_eq({tag, ".regwrite"}, ex_regwrite, m.regwrite);
    check_eq({tag, ".memread"}, ex_memread, m.memread);
    check_eq({tag, ".ctrl"}, ex_ctrl, m.ctrl);
    check_eq({tag, ".rd1"}, ex_rd1, m.rd1);
    check_eq({tag, ".rd2"}, ex_rd2, m.rd2);
    check_eq({tag, ".imm"}, ex_imm, m.imm);
    check_eq({tag, ".pc"}, ex_pc, m.pc);
    check_eq({tag, ".ra1"}, ex_ra1, m.ra1);
    check_eq({tag, ".ra2"}, ex_ra2, m.ra2);
    check_eq({tag, ".wa"}, ex_wa, m.wa);
`ifdef IDEX_BUBBLE_CNT_EN
    check_eq({tag, ".bubble_cnt"}, bubble_cnt, m_bubbles);
`endif
  endtask

  // Inputs are already set; check hazard, advance one edge, check EX.
  task automatic step(input string tag);
    logic  hz;
    slot_t nxt;
    #1;
    hz = model_hazard();
    last_hz = hazard_stall;
    check_eq({tag, ".hazard"}, hazard_stall, hz);
    if (flush)      nxt = empty_slot();
    else if (stall) nxt = m;
    else if (hz)    nxt = empty_slot();
    else            nxt = decoded_slot();
    if (hz && !stall && !flush && m_bubbles != 32'hFFFF_FFFF) m_bubbles++;
    @(posedge clk);
    m = nxt;
    #1;
    check_outputs(tag);
  endtask

  task automatic set_instr(input logic memread, input logic [AW-1:0] wa,
                           input logic [AW-1:0] ra1, input logic use1,
                           input logic [AW-1:0] ra2, input logic use2);
    id_valid = 1; id_regwrite = 1; id_memread = memread; id_wa = wa;
    id_ra1 = ra1; id_use_ra1 = use1; id_ra2 = ra2; id_use_ra2 = use2;
    id_rd1 = {$urandom, $urandom}; id_rd2 = {$urandom, $urandom};
    id_imm = {$urandom, $urandom}; id_pc = {$urandom, $urandom};
    id_ctrl = CW'($urandom);
  endtask

  function automatic logic [AW-1:0] pick_reg();
    case ($urandom_range(0, 3))
      0:       return 5'd9;
      1:       return 5'd31;
      2:       return 5'd5;
      default: return AW'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic rand_inputs();
    set_instr($urandom_range(0, 2) == 0, pick_reg(), pick_reg(), 1'($urandom),
              pick_reg(), 1'($urandom));
    id_valid    = $urandom_range(0, 7) != 0;
    id_regwrite = 1'($urandom);
    stall       = $urandom_range(0, 7) == 0;
    flush       = $urandom_range(0, 9) == 0;
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    m = empty_slot();
    m_bubbles = 0;
    check_outputs(tag);
    check_eq({tag, ".hazard"}, hazard_stall, 1'b0);
    #1 reset = 1'b0;
  endtask

  initial begin
    m = empty_slot();
    m_bubbles = 0;
    reset = 1; stall = 0; flush = 0;
    set_instr(1, 5'd9, 5'd9, 1, 5'd9, 1);
    #1;
    check_outputs("reset0");
    check_eq("reset0.hazard", hazard_stall, 1'b0);
    @(negedge clk);
    reset = 0;

    // Load something, then reset asynchronously mid-cycle with nonzero decode inputs.
    set_instr(1, 5'd7, 5'd1, 1, 5'd2, 1);
    step("preload");
    async_reset("midreset");
    check_eq("midreset.wa_is_zr", ex_wa, 5'd31);

    // Load-use: LDUR X9 then ADD reading X9.
    set_instr(1, 5'd9, 5'd1, 1, 5'd2, 0);
    step("ldur9");
    set_instr(0, 5'd10, 5'd9, 1, 5'd4, 1);
    step("add_hz");
    check_eq("add_hz.seen", last_hz, 1'b1);
    check_eq("add_hz.bubble", ex_valid, 1'b0);
    step("add_load");
    check_eq("add_load.seen", last_hz, 1'b0);
    check_eq("add_load.ra1", ex_ra1, 5'd9);
    check_eq("add_load.valid", ex_valid, 1'b1);

    // Load to XZR never triggers a hazard.
    set_instr(1, 5'd31, 5'd1, 0, 5'd2, 0);
    step("ldur31");
    set_instr(0, 5'd3, 5'd4, 0, 5'd31, 1);
    step("read31");
    check_eq("read31.seen", last_hz, 1'b0);
    check_eq("read31.valid", ex_valid, 1'b1);

    // External stall holds EX for three cycles.
    set_instr(0, 5'd6, 5'd1, 1, 5'd2, 1);
    id_rd1 = 64'h55;
    step("rd55");
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      id_rd1 = {$urandom, $urandom};
      step("stall");
      check_eq("stall.rd1", ex_rd1, 64'h55);
    end
    stall = 0;

    // Hazard under stall: load held, hazard persists, then exactly one bubble.
    set_instr(1, 5'd9, 5'd1, 0, 5'd2, 0);
    step("ldur9b");
    set_instr(0, 5'd11, 5'd3, 1, 5'd9, 1);
    stall = 1;
    step("hzstall1");
    check_eq("hzstall1.seen", last_hz, 1'b1);
    check_eq("hzstall1.memread", ex_memread, 1'b1);
    step("hzstall2");
    check_eq("hzstall2.seen", last_hz, 1'b1);
    stall = 0;
    step("hzbubble");
    check_eq("hzbubble.valid", ex_valid, 1'b0);
    step("hzdep");
    check_eq("hzdep.valid", ex_valid, 1'b1);
    check_eq("hzdep.ra2", ex_ra2, 5'd9);

    // Flush inserts an uncounted bubble.
    set_instr(0, 5'd12, 5'd1, 1, 5'd2, 1);
    id_rd2 = 64'hABCD;
    flush = 1;
    step("flush");
    check_eq("flush.valid", ex_valid, 1'b0);
    check_eq("flush.rd2", ex_rd2, 64'h0);
    check_eq("flush.ctrl", ex_ctrl, 8'h0);
    flush = 0;

    // Randomized traffic with occasional asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step("rand");
      if ($urandom_range(0, 199) == 0) async_reset("rand_reset");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
